// File: rtl/i2c_eeprom_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_eeprom_pkg
//  Description : Shared types and constants for the I2C EEPROM slave.
//                Holds the protocol state enum, the bit count of one byte
//                and the erased-cell value of the emulated memory.
//  Revision    : 1.0 - initial release
// ============================================================================
package i2c_eeprom_pkg;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        DEV_ADDR  = 4'd1,
        ACK_DEV   = 4'd2,
        WORD_ADDR = 4'd3,
        ACK_WORD  = 4'd4,
        WR_DATA   = 4'd5,
        ACK_WR    = 4'd6,
        RD_DATA   = 4'd7,
        RD_ACK    = 4'd8
    } i2c_state_e;

    localparam int         I2C_BITS_PER_BYTE = 8;
    localparam logic [7:0] EEPROM_ERASED     = 8'hFF;

endpackage : i2c_eeprom_pkg
`default_nettype wire

// File: rtl/i2c_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_sync_edge
//  Description : Two-flop synchronizer for one asynchronous bus line plus a
//                delayed copy used to detect rising and falling edges.
//  Ports       : clk_i   - system clock
//                rst_ni  - asynchronous active-low reset
//                d_i     - asynchronous pad level
//                level_o - synchronized level
//                rise_o  - one-cycle pulse on a detected 0->1 transition
//                fall_o  - one-cycle pulse on a detected 1->0 transition
//  Revision    : 1.0 - initial release
// ============================================================================
module i2c_sync_edge (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic dly_q;

    // Reset to 1: an idle I2C bus is pulled high, so no edge appears on release.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            dly_q  <= 1'b1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
            dly_q  <= sync_q;
        end
    end

    assign level_o = sync_q;
    assign rise_o  = sync_q & ~dly_q;
    assign fall_o  = ~sync_q & dly_q;

endmodule : i2c_sync_edge
`default_nettype wire

// File: rtl/i2c_eeprom_slave.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_eeprom_slave
//  Description : I2C slave emulating a 24C02-class serial EEPROM. Supports
//                byte/sequential write, random read and current-address read.
//                SCL/SDA are oversampled with clk_i; SDA is driven open-drain.
//  Ports       : clk_i    - system clock, rising edge
//                rst_ni   - asynchronous active-low reset
//                scl_i    - SCL pad level (asynchronous)
//                sda_i    - SDA pad level (asynchronous)
//                sda_oe_o - 1 pulls SDA low, 0 releases it
//  Revision    : 1.0 - initial release
// ============================================================================
module i2c_eeprom_slave
    import i2c_eeprom_pkg::*;
#(
    parameter logic [6:0] ADDRESS   = 7'b1010_000,
    parameter int         MEM_BYTES = 256
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_oe_o
);

    localparam int         AW       = $clog2(MEM_BYTES);
    // Bit counter milestones: last data bit, ACK slot driven, ACK slot sampled.
    localparam logic [3:0] LAST_BIT = 4'(I2C_BITS_PER_BYTE - 1);
    localparam logic [3:0] ACK_BIT  = 4'(I2C_BITS_PER_BYTE);
    localparam logic [3:0] ACK_DONE = 4'(I2C_BITS_PER_BYTE + 1);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;

    i2c_sync_edge u_scl_sync (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .d_i     (scl_i),
        .level_o (scl_lvl),
        .rise_o  (scl_rise),
        .fall_o  (scl_fall)
    );

    i2c_sync_edge u_sda_sync (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .d_i     (sda_i),
        .level_o (sda_lvl),
        .rise_o  (sda_rise),
        .fall_o  (sda_fall)
    );

    logic start_det, stop_det;
    assign start_det = sda_fall & scl_lvl;
    assign stop_det  = sda_rise & scl_lvl;

    i2c_state_e     state_q,   state_d;
    logic [3:0]     bit_cnt_q, bit_cnt_d;
    logic [7:0]     shift_q,   shift_d;
    logic [AW-1:0]  ptr_q,     ptr_d;
    logic           sda_oe_q,  sda_oe_d;
    logic           mem_we;
    logic [7:0]     mem_q [MEM_BYTES];
    logic [7:0]     mem_rd;
    logic [7:0]     byte_in;

    assign mem_rd  = mem_q[ptr_q];
    // Byte as it stands once the bit sampled this cycle is shifted in.
    assign byte_in = {shift_q[6:0], sda_lvl};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            bit_cnt_q <= 4'd0;
            shift_q   <= 8'd0;
            ptr_q     <= '0;
            sda_oe_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            ptr_q     <= ptr_d;
            sda_oe_q  <= sda_oe_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < MEM_BYTES; i++) begin
                mem_q[i] <= EEPROM_ERASED;
            end
        end else if (mem_we) begin
            mem_q[ptr_q] <= byte_in;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        ptr_d     = ptr_q;
        sda_oe_d  = sda_oe_q;
        mem_we    = 1'b0;

        if (start_det) begin
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b0;
            state_d   = DEV_ADDR;
        end else if (stop_det) begin
            sda_oe_d  = 1'b0;
            state_d   = IDLE;
        end else if (scl_rise) begin
            case (state_q)
                DEV_ADDR, WORD_ADDR, WR_DATA: begin
                    shift_d   = byte_in;
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == LAST_BIT) begin
                        if (state_q == DEV_ADDR) begin
                            state_d = (byte_in[7:1] == ADDRESS) ? ACK_DEV : IDLE;
                        end else if (state_q == WORD_ADDR) begin
                            ptr_d   = byte_in[AW-1:0];
                            state_d = ACK_WORD;
                        end else begin
                            mem_we  = 1'b1;
                            ptr_d   = ptr_q + 1'b1;
                            state_d = ACK_WR;
                        end
                    end
                end
                ACK_DEV, ACK_WORD, ACK_WR: begin
                    bit_cnt_d = ACK_DONE;
                end
                RD_DATA: begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end
                RD_ACK: begin
                    // Counter value 1 remembers the master's ACK until SCL falls.
                    if (!sda_lvl) begin
                        bit_cnt_d = 4'd1;
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: ;
            endcase
        end else if (scl_fall) begin
            case (state_q)
                ACK_DEV, ACK_WORD, ACK_WR: begin
                    if (bit_cnt_q == ACK_BIT) begin
                        sda_oe_d = 1'b1;
                    end else if (bit_cnt_q == ACK_DONE) begin
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = 4'd0;
                        // In ACK_DEV the shift register still holds the
                        // device byte, so bit 0 is the R/W flag.
                        if (state_q == ACK_DEV && shift_q[0]) begin
                            shift_d  = mem_rd;
                            sda_oe_d = ~mem_rd[7];
                            state_d  = RD_DATA;
                        end else if (state_q == ACK_DEV) begin
                            state_d  = WORD_ADDR;
                        end else begin
                            state_d  = WR_DATA;
                        end
                    end
                end
                RD_DATA: begin
                    if (bit_cnt_q == ACK_BIT) begin
                        sda_oe_d  = 1'b0;
                        ptr_d     = ptr_q + 1'b1;
                        bit_cnt_d = 4'd0;
                        state_d   = RD_ACK;
                    end else begin
                        shift_d  = {shift_q[6:0], 1'b0};
                        sda_oe_d = ~shift_q[6];
                    end
                end
                RD_ACK: begin
                    if (bit_cnt_q == 4'd1) begin
                        shift_d   = mem_rd;
                        sda_oe_d  = ~mem_rd[7];
                        bit_cnt_d = 4'd0;
                        state_d   = RD_DATA;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sda_oe_o = sda_oe_q;

endmodule : i2c_eeprom_slave
`default_nettype wire

// File: tb/tb_i2c_eeprom_slave.sv
`default_nettype none
// ============================================================================
//  Module      : tb_i2c_eeprom_slave
//  Description : Self-checking bench for i2c_eeprom_slave. A bit-banged I2C
//                master drives the bus; a byte-array EEPROM model with an
//                address pointer predicts ACKs and read data.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_eeprom_slave;
    import i2c_eeprom_pkg::*;

    localparam int Q = 40;   // quarter SCL period (4 clk periods)

    logic clk = 1'b0;
    logic rst_n;
    logic scl;
    logic sda_m;
    logic sda_oe;
    logic sda_line;

    assign sda_line = sda_m & ~sda_oe;

    always #5 clk = ~clk;

    i2c_eeprom_slave #(
        .ADDRESS   (7'b1010_000),
        .MEM_BYTES (256)
    ) dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .scl_i    (scl),
        .sda_i    (sda_line),
        .sda_oe_o (sda_oe)
    );

    int         total  = 0;
    int         passed = 0;
    int         failed = 0;
    logic [7:0] model_mem [256];
    logic [7:0] model_ptr;
    logic [7:0] wq [$];
    logic       mon_en  = 1'b0;
    logic       oe_seen = 1'b0;

    always @(negedge clk) if (mon_en && sda_oe) oe_seen = 1'b1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_erase();
        for (int i = 0; i < 256; i++) model_mem[i] = 8'hFF;
        model_ptr = 8'h00;
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; #Q; scl = 1'b1; #Q; sda_m = 1'b0; #Q; scl = 1'b0; #Q;
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; #Q; scl = 1'b1; #Q; sda_m = 1'b1; #Q;
    endtask

    task automatic send_bit(input logic b);
        sda_m = b; #Q; scl = 1'b1; #Q; #Q; scl = 1'b0; #Q;
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        sda_m = 1'b1; #Q; scl = 1'b1; #Q; ack = sda_line; #Q; scl = 1'b0; #Q;
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            sda_m = 1'b1; #Q; scl = 1'b1; #Q; b[i] = sda_line; #Q; scl = 1'b0; #Q;
        end
        send_bit(nack);
    endtask

    // Write the bytes queued in wq starting at word address addr.
    task automatic do_write(input logic [7:0] addr);
        logic ack;
        i2c_start();
        write_byte(8'hA0, ack); check("wr_dev_ack", ack, 0);
        write_byte(addr, ack);  check("wr_word_ack", ack, 0);
        model_ptr = addr;
        foreach (wq[k]) begin
            write_byte(wq[k], ack); check("wr_data_ack", ack, 0);
            model_mem[model_ptr] = wq[k];
            model_ptr = model_ptr + 8'd1;
        end
        i2c_stop();
    endtask

    // Read n bytes; random=1 sets the pointer first via a dummy write.
    task automatic do_read(input logic [7:0] addr, input int n, input logic random);
        logic       ack;
        logic [7:0] b;
        i2c_start();
        if (random) begin
            write_byte(8'hA0, ack); check("rd_dev_w_ack", ack, 0);
            write_byte(addr, ack);  check("rd_word_ack", ack, 0);
            model_ptr = addr;
            i2c_start();
        end
        write_byte(8'hA1, ack); check("rd_dev_r_ack", ack, 0);
        for (int k = 0; k < n; k++) begin
            read_byte(k == n - 1, b);
            check("rd_data", b, model_mem[model_ptr]);
            model_ptr = model_ptr + 8'd1;
        end
        i2c_stop();
    endtask

    initial begin
        logic       ack;
        logic [7:0] addr;
        int         n;

        model_erase();
        rst_n = 1'b0; scl = 1'b1; sda_m = 1'b1;
        repeat (5) @(negedge clk);
        check("reset_oe", sda_oe, 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Write then random read.
        wq = '{8'h5A};
        do_write(8'h10);
        do_read(8'h10, 1, 1'b1);

        // Address mismatch: no drive during the whole frame.
        oe_seen = 1'b0; mon_en = 1'b1;
        i2c_start();
        write_byte(8'hA2, ack); check("mis_dev_nack", ack, 1);
        write_byte(8'h00, ack); check("mis_byte_nack", ack, 1);
        i2c_stop();
        mon_en = 1'b0;
        check("mis_no_oe", oe_seen, 0);
        do_read(8'h10, 1, 1'b1);

        // Sequential write wrapping the top of the array, then current-address read.
        wq = '{8'h11, 8'h22, 8'h33};
        do_write(8'hFE);
        do_read(8'h00, 1, 1'b0);
        do_read(8'hFE, 3, 1'b1);

        // Sequential read with master ACKs.
        wq = '{8'h01, 8'h02, 8'h03, 8'h04};
        do_write(8'h20);
        do_read(8'h20, 4, 1'b1);
        repeat (4) @(negedge clk);
        check("idle_oe", sda_oe, 0);
        check("idle_state", 32'(dut.state_q), 32'(IDLE));

        // Randomized write/read-back rounds.
        for (int r = 0; r < 4; r++) begin
            addr = 8'($urandom_range(0, 255));
            n    = int'($urandom_range(1, 4));
            wq.delete();
            for (int k = 0; k < n; k++) wq.push_back(8'($urandom_range(0, 255)));
            do_write(addr);
            do_read(addr, n, 1'b1);
        end
        do_read(8'h00, 2, 1'b0);

        // STOP inside a data byte leaves the location untouched.
        wq = '{8'($urandom_range(0, 255))};
        do_write(8'h40);
        i2c_start();
        write_byte(8'hA0, ack); check("part_dev_ack", ack, 0);
        write_byte(8'h40, ack); check("part_word_ack", ack, 0);
        model_ptr = 8'h40;
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        i2c_stop();
        do_read(8'h40, 1, 1'b1);

        // Reset during the ACK bit of a write.
        i2c_start();
        write_byte(8'hA0, ack); check("abort_dev_ack", ack, 0);
        write_byte(8'h30, ack); check("abort_word_ack", ack, 0);
        for (int i = 7; i >= 0; i--) send_bit(1'b0);
        sda_m = 1'b1; #Q; scl = 1'b1; #Q;
        check("abort_ack_drive", sda_oe, 1);
        rst_n = 1'b0;
        #1;
        check("abort_oe_release", sda_oe, 0);
        #20;
        scl = 1'b0; sda_m = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #Q; scl = 1'b1; #Q; sda_m = 1'b1; #Q;
        model_erase();
        do_read(8'h30, 2, 1'b1);
        do_read(8'h10, 1, 1'b1);
        do_read(8'h20, 4, 1'b1);
        do_read(8'hFE, 3, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule : tb_i2c_eeprom_slave
`default_nettype wire
